cv32e41p_seq_hold_buffer: RTL

Holding stage between the instruction aligner and `cv32e41p_sequencer`. It captures one fetched instruction word together with its PC and keeps both stable while the sequencer expands that word into several sub-instructions. It back-pressures fetch until the sequencer reports the last sub-instruction, and it marks the sequence as non-interruptible. It also carries a step counter and a watchdog so that a runaway sequence is detected.

---
 rtl/cv32e41p_sequencer_pkg.sv | 15 +
 rtl/cv32e41p_seq_hold_buffer.sv | 100 ++++++++++
 2 files changed

// File: rtl/cv32e41p_sequencer_pkg.sv
// rtl/cv32e41p_sequencer_pkg.sv - shared types for the sequencer and its hold buffer
package cv32e41p_sequencer_pkg;

   localparam int unsigned SEQ_W = 5;

   // Sub-instruction index within one sequenced word
   typedef logic [SEQ_W-1:0] seq_i;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HOLD  = 2'd1,
      SEQ   = 2'd2
   } hold_state_e;

endpackage

// File: rtl/cv32e41p_seq_hold_buffer.sv
// rtl/cv32e41p_seq_hold_buffer.sv - holds one fetched word and PC stable while the sequencer expands it
module cv32e41p_seq_hold_buffer
   import cv32e41p_sequencer_pkg::*;
#(
   parameter int unsigned MAX_SEQ_STEPS = 31
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             flush_i,
   input  logic             fetch_valid_i,
   input  logic [31:0]      fetch_rdata_i,
   input  logic [31:0]      fetch_pc_i,
   output logic             fetch_ready_o,
   output logic [31:0]      instr_rdata_o,
   output logic [31:0]      pc_o,
   output logic             instr_valid_o,
   input  logic             id_ready_i,
   output logic             if_valid_o,
   input  logic             is_sequenced_i,
   input  logic             seq_finished_i,
   output logic             seq_busy_o,
   output logic [SEQ_W-1:0] seq_step_o,
   output logic             seq_error_o
);

   localparam logic [SEQ_W-1:0] MAX_STEP = SEQ_W'(MAX_SEQ_STEPS);

   hold_state_e      state_q;
   logic [31:0]      rdata_q;
   logic [31:0]      pc_q;
   logic [SEQ_W-1:0] step_q;
   logic             error_q;
   logic             done;
   logic             capture;

   assign instr_valid_o = (state_q != EMPTY);
   assign if_valid_o    = instr_valid_o & id_ready_i & ~flush_i;
   assign done          = if_valid_o & (~is_sequenced_i | seq_finished_i);
   assign fetch_ready_o = ~flush_i & ((state_q == EMPTY) | done);
   assign capture       = fetch_valid_i & fetch_ready_o;
   assign seq_busy_o    = (state_q == SEQ);

   assign instr_rdata_o = rdata_q;
   assign pc_o          = pc_q;
   assign seq_step_o    = step_q;
   assign seq_error_o   = error_q;

   // Data/PC only ever load on a capture so the sequencer sees a constant word
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rdata_q <= '0;
         pc_q    <= '0;
      end else if (capture) begin
         rdata_q <= fetch_rdata_i;
         pc_q    <= fetch_pc_i;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= EMPTY;
         step_q  <= '0;
         error_q <= 1'b0;
      end else begin
         error_q <= 1'b0;
         if (flush_i) begin
            state_q <= EMPTY;
            step_q  <= '0;
         end else if (done) begin
            state_q <= fetch_valid_i ? HOLD : EMPTY;
            step_q  <= '0;
         end else if (state_q == EMPTY) begin
            if (fetch_valid_i) begin
               state_q <= HOLD;
            end
         end else if (if_valid_o) begin
            // Accepted sub-instruction that is not the last one
            if (state_q == HOLD) begin
               state_q <= SEQ;
               step_q  <= SEQ_W'(1);
            end else if (step_q == MAX_STEP) begin
               state_q <= EMPTY;
               step_q  <= '0;
               error_q <= 1'b1;
            end else begin
               step_q  <= step_q + SEQ_W'(1);
            end
         end
      end
   end

`ifdef CV32E41P_ASSERT_ON
   a_word_stable : assert property (@(posedge clk) disable iff (!n_rst)
      (seq_busy_o && $past(seq_busy_o)) |-> $stable(instr_rdata_o));

   a_seq_backpressure : assert property (@(posedge clk) disable iff (!n_rst)
      ((state_q == SEQ) && !done) |-> !fetch_ready_o);
`endif

endmodule
